// File: rtl/cross_bar_bank_arb.sv
// cross_bar_bank_arb
//
// Per-bank arbiter for the 3-channel x 4-bank cross bar. Each bank has one
// instance, which shares that bank among the three channel request queues.
// In each cycle it picks one channel whose oldest entry for this bank is
// pending. The pick is round-robin across channels. A bank credit counter
// gates each grant. The winner is loaded into a single-entry output register
// that drives the bank. In the same cycle, the winning channel gets a
// one-cycle grant pulse so it can retire its entry.
//
// Ports:
//   clk_i             clock
//   rst_i             asynchronous active-high reset
//   ch_req_valid_i    per-channel pending request for this bank
//   ch_entry_id_i     packed entry ids, channel k at [k*EID_W +: EID_W]
//   ch_payload_i      packed payloads, channel k at [k*PAYLOAD_W +: PAYLOAD_W]
//   ch_grant_o        one-hot single-cycle grant (combinational)
//   bank_valid_o      output register holds a request
//   bank_ready_i      bank accepts the held request this cycle
//   bank_ch_id_o      source channel of the held request
//   bank_entry_id_o   source entry id of the held request
//   bank_payload_o    payload of the held request
//   credit_return_i   bank frees one slot
//   credit_overflow_o sticky: credit returned while counter was full

module cross_bar_bank_arb #(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned EID_W     = 3,
  parameter int unsigned CREDITS   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             ch_req_valid_i,
  input  logic [3*EID_W-1:0]     ch_entry_id_i,
  input  logic [3*PAYLOAD_W-1:0] ch_payload_i,
  output logic [2:0]             ch_grant_o,
  output logic                   bank_valid_o,
  input  logic                   bank_ready_i,
  output logic [1:0]             bank_ch_id_o,
  output logic [EID_W-1:0]       bank_entry_id_o,
  output logic [PAYLOAD_W-1:0]   bank_payload_o,
  input  logic                   credit_return_i,
  output logic                   credit_overflow_o
);

  localparam int unsigned CntW = $clog2(CREDITS + 1);
  localparam logic [CntW-1:0] CreditsMax = CntW'(CREDITS);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  // State
  logic [1:0]      rr_q, rr_d;
  logic [CntW-1:0] credit_cnt_q, credit_cnt_d;
  logic            overflow_q, overflow_d;

  // Arbitration
  logic            fire;
  logic            slot_free;
  logic            grant;
  logic [1:0]      cand0, cand1, cand2;
  logic            win_found;
  logic [1:0]      win_idx;
  logic [EID_W-1:0]     win_entry_id;
  logic [PAYLOAD_W-1:0] win_payload;

  assign fire      = bank_valid_o & bank_ready_i;
  assign slot_free = ~bank_valid_o | fire;

  // Search order starting at the round-robin pointer.
  always_comb begin
    cand0 = 2'd0;
    cand1 = 2'd1;
    cand2 = 2'd2;
    case (rr_q)
      2'd1: begin
        cand0 = 2'd1;
        cand1 = 2'd2;
        cand2 = 2'd0;
      end
      2'd2: begin
        cand0 = 2'd2;
        cand1 = 2'd0;
        cand2 = 2'd1;
      end
      default: begin
        cand0 = 2'd0;
        cand1 = 2'd1;
        cand2 = 2'd2;
      end
    endcase
  end

  always_comb begin
    win_found = 1'b1;
    win_idx   = 2'd0;
    if (ch_req_valid_i[cand0]) begin
      win_idx = cand0;
    end else if (ch_req_valid_i[cand1]) begin
      win_idx = cand1;
    end else if (ch_req_valid_i[cand2]) begin
      win_idx = cand2;
    end else begin
      win_found = 1'b0;
    end
  end

  always_comb begin
    win_entry_id = ch_entry_id_i[0 +: EID_W];
    win_payload  = ch_payload_i[0 +: PAYLOAD_W];
    case (win_idx)
      2'd1: begin
        win_entry_id = ch_entry_id_i[EID_W +: EID_W];
        win_payload  = ch_payload_i[PAYLOAD_W +: PAYLOAD_W];
      end
      2'd2: begin
        win_entry_id = ch_entry_id_i[2*EID_W +: EID_W];
        win_payload  = ch_payload_i[2*PAYLOAD_W +: PAYLOAD_W];
      end
      default: begin
        win_entry_id = ch_entry_id_i[0 +: EID_W];
        win_payload  = ch_payload_i[0 +: PAYLOAD_W];
      end
    endcase
  end

  // Reset masks the grant so no channel retires an entry while rst_i is high.
  assign grant = slot_free & (credit_cnt_q != '0) & win_found & ~rst_i;

  always_comb begin
    ch_grant_o = 3'b000;
    if (grant) begin
      ch_grant_o[win_idx] = 1'b1;
    end
  end

  // Pointer moves one past the winner.
  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end
  end

  // Credit counter. A return and a grant in the same cycle cancel out. A
  // return at full count saturates the counter and flags overflow.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    overflow_d   = overflow_q;
    case ({grant, credit_return_i})
      2'b10: credit_cnt_d = credit_cnt_q - CntOne;
      2'b01: begin
        if (credit_cnt_q == CreditsMax) begin
          overflow_d = 1'b1;
        end else begin
          credit_cnt_d = credit_cnt_q + CntOne;
        end
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= 2'd0;
      credit_cnt_q <= CreditsMax;
      overflow_q   <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      credit_cnt_q <= credit_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Single-entry output register. The data fields keep their last value
  // after the request leaves; only the valid bit drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_valid_o    <= 1'b0;
      bank_ch_id_o    <= 2'd0;
      bank_entry_id_o <= '0;
      bank_payload_o  <= '0;
    end else if (grant) begin
      bank_valid_o    <= 1'b1;
      bank_ch_id_o    <= win_idx;
      bank_entry_id_o <= win_entry_id;
      bank_payload_o  <= win_payload;
    end else if (fire) begin
      bank_valid_o    <= 1'b0;
    end
  end

  assign credit_overflow_o = overflow_q;

endmodule

// File: tb/tb_cross_bar_bank_arb.sv
module tb_cross_bar_bank_arb;

  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned EID_W     = 3;
  localparam int unsigned CREDITS   = 4;

  logic                   clk_i;
  logic                   rst_i;
  logic [2:0]             ch_req_valid_i;
  logic [3*EID_W-1:0]     ch_entry_id_i;
  logic [3*PAYLOAD_W-1:0] ch_payload_i;
  logic [2:0]             ch_grant_o;
  logic                   bank_valid_o;
  logic                   bank_ready_i;
  logic [1:0]             bank_ch_id_o;
  logic [EID_W-1:0]       bank_entry_id_o;
  logic [PAYLOAD_W-1:0]   bank_payload_o;
  logic                   credit_return_i;
  logic                   credit_overflow_o;

  int n_cmp;
  int n_fail;

  cross_bar_bank_arb #(
    .PAYLOAD_W(PAYLOAD_W),
    .EID_W    (EID_W),
    .CREDITS  (CREDITS)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ch_req_valid_i   (ch_req_valid_i),
    .ch_entry_id_i    (ch_entry_id_i),
    .ch_payload_i     (ch_payload_i),
    .ch_grant_o       (ch_grant_o),
    .bank_valid_o     (bank_valid_o),
    .bank_ready_i     (bank_ready_i),
    .bank_ch_id_o     (bank_ch_id_o),
    .bank_entry_id_o  (bank_entry_id_o),
    .bank_payload_o   (bank_payload_o),
    .credit_return_i  (credit_return_i),
    .credit_overflow_o(credit_overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    ch_req_valid_i  = 3'b000;
    ch_entry_id_i   = '0;
    ch_payload_i    = '0;
    bank_ready_i    = 1'b0;
    credit_return_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  // Distinct entry ids / payloads per channel: ch0 {1,0x100}, ch1 {2,0x201}, ch2 {3,0x302}.
  task automatic set_default_data();
    ch_entry_id_i = {3'd3, 3'd2, 3'd1};
    ch_payload_i  = {32'h0000_0302, 32'h0000_0201, 32'h0000_0100};
  endtask

  task automatic test_reset();
    rst_i           = 1'b1;
    ch_req_valid_i  = 3'b111;
    set_default_data();
    bank_ready_i    = 1'b1;
    credit_return_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (ch_grant_o !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_grant: got %b want 000", ch_grant_o);
    end
    n_cmp++;
    if (bank_valid_o !== 1'b0 || bank_ch_id_o !== 2'd0 || bank_entry_id_o !== 3'd0 ||
        bank_payload_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bank: got v=%b ch=%0d eid=%0d pl=%h want all zero",
               bank_valid_o, bank_ch_id_o, bank_entry_id_o, bank_payload_o);
    end
    n_cmp++;
    if (credit_overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overflow: got %b want 0", credit_overflow_o);
    end
    ch_req_valid_i = 3'b000;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int gcount;
    do_reset();
    ch_req_valid_i = 3'b010;
    ch_entry_id_i  = {3'd0, 3'd4, 3'd0};
    ch_payload_i   = {32'd0, 32'h0000_00A5, 32'd0};
    bank_ready_i   = 1'b1;
    #1;
    n_cmp++;
    if (ch_grant_o !== 3'b010) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 010", ch_grant_o);
    end
    tick();
    ch_req_valid_i = 3'b000;
    #1;
    n_cmp++;
    if (bank_valid_o !== 1'b1 || bank_ch_id_o !== 2'd1 || bank_entry_id_o !== 3'd4 ||
        bank_payload_o !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL single_bank: got v=%b ch=%0d eid=%0d pl=%h want v=1 ch=1 eid=4 pl=a5",
               bank_valid_o, bank_ch_id_o, bank_entry_id_o, bank_payload_o);
    end
    // Three credits remain: ch0 held valid with no returns gets exactly three grants.
    ch_req_valid_i = 3'b001;
    gcount = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ch_grant_o == 3'b001) gcount++;
      tick();
    end
    n_cmp++;
    if (gcount != 3) begin
      n_fail++;
      $display("FAIL single_credits_left: got %0d grants want 3", gcount);
    end
    ch_req_valid_i = 3'b000;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    logic [1:0] exp_id [6];
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    set_default_data();
    ch_req_valid_i  = 3'b111;
    bank_ready_i    = 1'b1;
    credit_return_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (ch_grant_o !== exp_g[i]) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, ch_grant_o, exp_g[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (bank_valid_o !== 1'b1 || bank_ch_id_o !== exp_id[i-1]) begin
          n_fail++;
          $display("FAIL rr_bank[%0d]: got v=%b ch=%0d want v=1 ch=%0d",
                   i, bank_valid_o, bank_ch_id_o, exp_id[i-1]);
        end
      end
      tick();
    end
    n_cmp++;
    if (credit_overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_overflow: got %b want 0", credit_overflow_o);
    end
    ch_req_valid_i  = 3'b000;
    credit_return_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    set_default_data();
    ch_req_valid_i = 3'b001;
    bank_ready_i   = 1'b0;
    #1;
    n_cmp++;
    if (ch_grant_o !== 3'b001) begin
      n_fail++;
      $display("FAIL bp_first_grant: got %b want 001", ch_grant_o);
    end
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ch_grant_o !== 3'b000 || bank_valid_o !== 1'b1 || bank_ch_id_o !== 2'd0 ||
          bank_entry_id_o !== 3'd1 || bank_payload_o !== 32'h0000_0100) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
    end
    // Ready rises with ch0 and ch1 valid: pointer sits at ch1.
    ch_req_valid_i = 3'b011;
    bank_ready_i   = 1'b1;
    #1;
    n_cmp++;
    if (ch_grant_o !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release_grant: got %b want 010", ch_grant_o);
    end
    tick();
    ch_req_valid_i = 3'b000;
    #1;
    n_cmp++;
    if (bank_valid_o !== 1'b1 || bank_ch_id_o !== 2'd1 || bank_entry_id_o !== 3'd2) begin
      n_fail++;
      $display("FAIL bp_release_bank: got v=%b ch=%0d eid=%0d want v=1 ch=1 eid=2",
               bank_valid_o, bank_ch_id_o, bank_entry_id_o);
    end
    tick();
    n_cmp++;
    if (bank_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got v=%b want 0", bank_valid_o);
    end
  endtask

  task automatic test_credit();
    logic [2:0] exp_g [13];
    logic       ret   [13];
    // 4 grants, 3 blocked, return@7 -> grant@8, return@9 (no grant, cnt 0),
    // return+grant@10 (cnt stays 1), grant@11, blocked@12.
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000,
              3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000};
    ret   = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    do_reset();
    set_default_data();
    ch_req_valid_i = 3'b001;
    bank_ready_i   = 1'b1;
    for (int i = 0; i < 13; i++) begin
      credit_return_i = ret[i];
      #1;
      n_cmp++;
      if (ch_grant_o !== exp_g[i]) begin
        n_fail++;
        $display("FAIL credit_grant[%0d]: got %b want %b", i, ch_grant_o, exp_g[i]);
      end
      tick();
    end
    credit_return_i = 1'b0;
    ch_req_valid_i  = 3'b000;
  endtask

  task automatic test_overflow();
    int gcount;
    do_reset();
    set_default_data();
    bank_ready_i    = 1'b1;
    credit_return_i = 1'b1;
    #1;
    n_cmp++;
    if (credit_overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_before: got %b want 0", credit_overflow_o);
    end
    tick();
    credit_return_i = 1'b0;
    #1;
    n_cmp++;
    if (credit_overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want 1", credit_overflow_o);
    end
    // Counter saturated at 4: exactly four grants with no further returns.
    ch_req_valid_i = 3'b001;
    gcount = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (ch_grant_o == 3'b001) gcount++;
      tick();
    end
    n_cmp++;
    if (gcount != 4) begin
      n_fail++;
      $display("FAIL ovf_saturate: got %0d grants want 4", gcount);
    end
    n_cmp++;
    if (credit_overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", credit_overflow_o);
    end
    ch_req_valid_i = 3'b000;
    do_reset();
    n_cmp++;
    if (credit_overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: got %b want 0", credit_overflow_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [2:0] exp_g [5];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    do_reset();
    set_default_data();
    ch_req_valid_i = 3'b001;
    bank_ready_i   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bank_ready_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bank_valid_o !== 1'b1 || ch_grant_o !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_setup: got v=%b g=%b want v=1 g=000", bank_valid_o, ch_grant_o);
    end
    // Asynchronous reset mid-cycle.
    #2;
    rst_i = 1'b1;
    ch_req_valid_i = 3'b111;
    #1;
    n_cmp++;
    if (bank_valid_o !== 1'b0 || ch_grant_o !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_async_rst: got v=%b g=%b want v=0 g=000", bank_valid_o, ch_grant_o);
    end
    tick();
    rst_i        = 1'b0;
    bank_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (ch_grant_o !== exp_g[i]) begin
        n_fail++;
        $display("FAIL post_rst_grant[%0d]: got %b want %b", i, ch_grant_o, exp_g[i]);
      end
      tick();
    end
    ch_req_valid_i = 3'b000;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_i           = 1'b1;
    ch_req_valid_i  = 3'b000;
    ch_entry_id_i   = '0;
    ch_payload_i    = '0;
    bank_ready_i    = 1'b0;
    credit_return_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_credit();
    test_overflow();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
